// File: rtl/data_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_uart_pkg
// Description : Shared FSM state encoding and 8N1 frame constants for the
//               storage-to-UART sender.
// Revision    : 1.0 - initial release
// ============================================================================
package data_uart_pkg;

    localparam int unsigned c_STATE_W = 3;

    localparam logic [2:0] c_STATE_IDLE       = 3'd0;
    localparam logic [2:0] c_STATE_FETCH      = 3'd1;
    localparam logic [2:0] c_STATE_WAIT_VALID = 3'd2;
    localparam logic [2:0] c_STATE_SEND       = 3'd3;
    localparam logic [2:0] c_STATE_CHECKSUM   = 3'd4;

    // Start + 8 data + stop.
    localparam int unsigned c_UART_FRAME_BITS = 10;
    localparam logic [3:0]  c_UART_LAST_BIT   = 4'(c_UART_FRAME_BITS - 1);

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 serializer; a load strobe starts a frame, o_done pulses
//               during the last cycle of the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);
    import data_uart_pkg::*;

    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_baud;
    logic [3:0]  r_bitIdx;
    logic [8:0]  r_shift;
    logic        r_active;
    logic        r_tx;
    logic        w_bitEnd;

    assign w_bitEnd = r_active && (r_baud == c_BAUD_LAST);
    assign o_done   = w_bitEnd && (r_bitIdx == c_UART_LAST_BIT);
    assign o_tx     = r_tx;

    // A load in the same cycle as o_done lets a follow-on frame start with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_baud   <= 16'd0;
            r_bitIdx <= 4'd0;
            r_shift  <= 9'h1FF;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_tx     <= 1'b0;
            r_baud   <= 16'd0;
            r_bitIdx <= 4'd0;
            r_shift  <= {1'b1, i_data};
        end else if (w_bitEnd) begin
            r_baud <= 16'd0;
            if (r_bitIdx == c_UART_LAST_BIT) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_bitIdx <= r_bitIdx + 4'd1;
                r_tx     <= r_shift[0];
                r_shift  <= {1'b1, r_shift[8:1]};
            end
        end else if (r_active) begin
            r_baud <= r_baud + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_uart_sender.sv
`default_nettype none
// ============================================================================
// Module      : data_uart_sender
// Description : Pops bytes from storage one at a time and sends them 8N1.
//               Define DATA_UART_SENDER_CHECKSUM_EN to append an XOR byte
//               after every FRAME_BYTES payload bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module data_uart_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BYTES  = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataValid,
    input  logic       DataReadyToSend,
    input  logic       TxEnable,
    output logic       ReadEnable,
    output logic       Tx,
    output logic       Busy,
    output logic [7:0] ByteCount
);
    import data_uart_pkg::*;

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
            FRAME_BYTES < 1 || FRAME_BYTES > 255) begin : g_bad_params
            $error("data_uart_sender: parameter out of legal range");
        end
    endgenerate

    logic [c_STATE_W-1:0] r_state;
    logic                 r_validMiss;
    logic [7:0]           r_byteCount;
    logic                 w_serLoad;
    logic                 w_serDone;
    logic [7:0]           w_serData;

`ifdef DATA_UART_SENDER_CHECKSUM_EN
    localparam logic [7:0] c_FRAME_LAST = 8'(FRAME_BYTES - 1);

    logic [7:0] r_xor;
    logic       w_frameEnd;

    assign w_frameEnd = (r_state == c_STATE_SEND) && w_serDone &&
                        (r_byteCount == c_FRAME_LAST);
`endif

    assign ReadEnable = (r_state == c_STATE_FETCH);
    assign Busy       = (r_state != c_STATE_IDLE);
    assign ByteCount  = r_byteCount;

    always_comb begin
        w_serLoad = (r_state == c_STATE_WAIT_VALID) && DataValid;
        w_serData = DataIn;
`ifdef DATA_UART_SENDER_CHECKSUM_EN
        // r_xor already folds in the closing payload byte, latched in WAIT_VALID.
        if (w_frameEnd) begin
            w_serLoad = 1'b1;
            w_serData = r_xor;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= c_STATE_IDLE;
            r_validMiss <= 1'b0;
            r_byteCount <= 8'd0;
`ifdef DATA_UART_SENDER_CHECKSUM_EN
            r_xor       <= 8'd0;
`endif
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (DataReadyToSend && TxEnable) begin
                        r_state <= c_STATE_FETCH;
                    end
                end
                c_STATE_FETCH: begin
                    r_state     <= c_STATE_WAIT_VALID;
                    r_validMiss <= 1'b0;
                end
                c_STATE_WAIT_VALID: begin
                    if (DataValid) begin
                        r_state <= c_STATE_SEND;
`ifdef DATA_UART_SENDER_CHECKSUM_EN
                        r_xor   <= r_xor ^ DataIn;
`endif
                    end else if (r_validMiss) begin
                        r_state <= c_STATE_IDLE;
                    end else begin
                        r_validMiss <= 1'b1;
                    end
                end
                c_STATE_SEND: begin
                    if (w_serDone) begin
                        r_byteCount <= r_byteCount + 8'd1;
`ifdef DATA_UART_SENDER_CHECKSUM_EN
                        r_state     <= w_frameEnd ? c_STATE_CHECKSUM : c_STATE_IDLE;
`else
                        r_state     <= c_STATE_IDLE;
`endif
                    end
                end
`ifdef DATA_UART_SENDER_CHECKSUM_EN
                c_STATE_CHECKSUM: begin
                    if (w_serDone) begin
                        r_byteCount <= 8'd0;
                        r_xor       <= 8'd0;
                        r_state     <= c_STATE_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk    (Clock),
        .rst    (Reset),
        .i_load (w_serLoad),
        .i_data (w_serData),
        .o_tx   (Tx),
        .o_done (w_serDone)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_uart_sender.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_uart_sender
// Description : Self-checking bench: storage responder, UART line decoder and
//               a frame-level model of the expected byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_uart_sender;

    localparam int CPB   = 4;
    localparam int FRAME = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] DataIn = 8'd0;
    logic       DataValid = 1'b0;
    logic       DataReadyToSend = 1'b0;
    logic       TxEnable = 1'b0;
    logic       ReadEnable;
    logic       Tx;
    logic       Busy;
    logic [7:0] ByteCount;

    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         reCount = 0;
    bit         withhold = 1'b0;

    logic [7:0] storeQ[$];
    logic [7:0] payQ[$];
    logic [7:0] expBytes[$];
    bit         expChk[$];
    logic [7:0] rxQ[$];
    int         rxStart[$];
    logic       rxStop[$];

    data_uart_sender #(
        .CLKS_PER_BIT (CPB),
        .FRAME_BYTES  (FRAME)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .DataIn          (DataIn),
        .DataValid       (DataValid),
        .DataReadyToSend (DataReadyToSend),
        .TxEnable        (TxEnable),
        .ReadEnable      (ReadEnable),
        .Tx              (Tx),
        .Busy            (Busy),
        .ByteCount       (ByteCount)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cycle <= cycle + 1;

    // Storage: a pop request is answered with data one cycle later.
    initial begin : storage
        logic reSeen;
        forever begin
            @(negedge Clock);
            reSeen = ReadEnable;
            if (reSeen === 1'b1) reCount++;
            @(posedge Clock);
            #1;
            if (reSeen === 1'b1 && !withhold && storeQ.size() > 0) begin
                DataValid = 1'b1;
                DataIn    = storeQ.pop_front();
            end else begin
                DataValid = 1'b0;
            end
            DataReadyToSend = (storeQ.size() != 0);
        end
    end

    // Line decoder: finds a start bit, samples each bit at its centre.
    initial begin : decoder
        logic [7:0] b;
        logic       stopBit;
        int         s;
        forever begin
            @(negedge Clock);
            if (Tx === 1'b0 && Reset === 1'b0) begin
                s = cycle;
                repeat (CPB / 2) @(negedge Clock);
                if (Tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) @(negedge Clock);
                        b[k] = Tx;
                    end
                    repeat (CPB) @(negedge Clock);
                    stopBit = Tx;
                    rxQ.push_back(b);
                    rxStart.push_back(s);
                    rxStop.push_back(stopBit);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line stream: payload in order, XOR byte after every FRAME payload bytes.
    function automatic void model_stream();
        logic [7:0] acc;
        int         n;
        acc = 8'd0;
        n   = 0;
        expBytes.delete();
        expChk.delete();
        foreach (payQ[i]) begin
            expBytes.push_back(payQ[i]);
            expChk.push_back(1'b0);
`ifdef DATA_UART_SENDER_CHECKSUM_EN
            acc = acc ^ payQ[i];
            n++;
            if (n == FRAME) begin
                expBytes.push_back(acc);
                expChk.push_back(1'b1);
                acc = 8'd0;
                n   = 0;
            end
`endif
        end
    endfunction

    function automatic logic [7:0] exp_count(input int n);
`ifdef DATA_UART_SENDER_CHECKSUM_EN
        return 8'(n % FRAME);
`else
        return 8'(n % 256);
`endif
    endfunction

    task automatic apply_reset();
        @(negedge Clock);
        Reset    = 1'b1;
        TxEnable = 1'b0;
        withhold = 1'b0;
        storeQ.delete();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        rxQ.delete();
        rxStart.delete();
        rxStop.delete();
        payQ.delete();
        reCount = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit timedOut);
        int k;
        k = 0;
        while (rxQ.size() < n && k < budget) begin
            @(negedge Clock);
            k++;
        end
        timedOut = (rxQ.size() < n);
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset    = 1'b1;
        TxEnable = 1'b1;
        storeQ.push_back(8'h55);
        repeat (3) @(negedge Clock);
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", Tx); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (ReadEnable !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", ReadEnable); end
        checks++; if (ByteCount !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ByteCount); end
        TxEnable = 1'b0;
        storeQ.delete();
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_a5_waveform();
        logic [7:0] val;
        logic       expTx;
        int         k;
        int         bitN;
        val = 8'hA5;
        apply_reset();
        payQ.push_back(val);
        storeQ.push_back(val);
        TxEnable = 1'b1;
        k = 0;
        while (DataValid !== 1'b1 && k < 20) begin @(negedge Clock); k++; end
        checks++; if (DataValid !== 1'b1) begin failures++; $display("FAIL a5_datavalid got=%b exp=1", DataValid); end
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL a5_tx_before_start got=%b exp=1", Tx); end
        for (int i = 0; i <= 10 * CPB; i++) begin
            @(negedge Clock);
            bitN = i / CPB;
            if (bitN == 0) expTx = 1'b0;
            else if (bitN >= 9) expTx = 1'b1;
            else expTx = val[bitN - 1];
            checks++;
            if (Tx !== expTx) begin failures++; $display("FAIL a5_wave cycle=%0d got=%b exp=%b", i, Tx, expTx); end
        end
        repeat (5) @(negedge Clock);
        checks++; if (reCount != 1) begin failures++; $display("FAIL a5_read_pulses got=%0d exp=1", reCount); end
        checks++; if (ByteCount !== exp_count(1)) begin failures++; $display("FAIL a5_count got=%0d exp=%0d", ByteCount, exp_count(1)); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL a5_busy_after got=%b exp=0", Busy); end
    endtask

    // Shared stream comparison body is inlined per test on purpose.
    task automatic test_back_to_back();
        bit to;
        int gap;
        apply_reset();
        payQ = '{8'h01, 8'h02, 8'h03};
        foreach (payQ[i]) storeQ.push_back(payQ[i]);
        repeat (3) @(negedge Clock);
        TxEnable = 1'b1;
        model_stream();
        wait_rx(expBytes.size(), 60 * expBytes.size() + 50, to);
        checks++; if (to) begin failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        repeat (60) @(negedge Clock);
        checks++; if (rxQ.size() != expBytes.size()) begin failures++; $display("FAIL b2b_size got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        for (int i = 0; i < rxQ.size() && i < expBytes.size(); i++) begin
            checks++; if (rxQ[i] !== expBytes[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rxQ[i], expBytes[i]); end
            checks++; if (rxStop[i] !== 1'b1) begin failures++; $display("FAIL b2b_stop%0d got=%b exp=1", i, rxStop[i]); end
            if (i > 0) begin
                gap = rxStart[i] - rxStart[i-1] - 10 * CPB;
                checks++; if (gap != (expChk[i] ? 0 : 3)) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, gap, expChk[i] ? 0 : 3); end
            end
        end
        checks++; if (reCount != 3) begin failures++; $display("FAIL b2b_read_pulses got=%0d exp=3", reCount); end
        checks++; if (ByteCount !== exp_count(3)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", ByteCount, exp_count(3)); end
    endtask

    task automatic test_missing_valid();
        int  k;
        bit  txLow;
        apply_reset();
        withhold = 1'b1;
        storeQ.push_back(8'h77);
        TxEnable = 1'b1;
        k = 0;
        while (ReadEnable !== 1'b1 && k < 20) begin @(negedge Clock); k++; end
        checks++; if (ReadEnable !== 1'b1) begin failures++; $display("FAIL nv_fetch got=%b exp=1", ReadEnable); end
        TxEnable = 1'b0;
        txLow = (Tx !== 1'b1);
        @(negedge Clock);
        txLow |= (Tx !== 1'b1);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL nv_busy_wait1 got=%b exp=1", Busy); end
        @(negedge Clock);
        txLow |= (Tx !== 1'b1);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL nv_busy_wait2 got=%b exp=1", Busy); end
        @(negedge Clock);
        txLow |= (Tx !== 1'b1);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL nv_busy_idle got=%b exp=0", Busy); end
        checks++; if (ReadEnable !== 1'b0) begin failures++; $display("FAIL nv_re_idle got=%b exp=0", ReadEnable); end
        repeat (40) begin @(negedge Clock); txLow |= (Tx !== 1'b1); end
        checks++; if (txLow) begin failures++; $display("FAIL nv_tx_low got=1 exp=0"); end
        checks++; if (rxQ.size() != 0) begin failures++; $display("FAIL nv_rx_bytes got=%0d exp=0", rxQ.size()); end
        checks++; if (reCount != 1) begin failures++; $display("FAIL nv_read_pulses got=%0d exp=1", reCount); end
        withhold = 1'b0;
        storeQ.delete();
    endtask

    task automatic test_reset_mid_byte();
        int         k;
        bit         to;
        logic [7:0] b;
        apply_reset();
        storeQ.push_back(8'h3C);
        TxEnable = 1'b1;
        k = 0;
        while (Tx !== 1'b0 && k < 20) begin @(negedge Clock); k++; end
        checks++; if (Tx !== 1'b0) begin failures++; $display("FAIL rm_start got=%b exp=0", Tx); end
        repeat (4 * CPB + 1) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL rm_tx got=%b exp=1", Tx); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", Busy); end
        checks++; if (ReadEnable !== 1'b0) begin failures++; $display("FAIL rm_re got=%b exp=0", ReadEnable); end
        checks++; if (ByteCount !== 8'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", ByteCount); end
        Reset = 1'b0;
        repeat (60) @(negedge Clock);
        rxQ.delete();
        rxStart.delete();
        rxStop.delete();
        reCount = 0;
        b = 8'($urandom);
        payQ.delete();
        payQ.push_back(b);
        storeQ.push_back(b);
        wait_rx(1, 100, to);
        checks++; if (to) begin failures++; $display("FAIL rm_next_timeout got=%0d exp=1", rxQ.size()); end
        repeat (20) @(negedge Clock);
        checks++; if (rxQ.size() != 1) begin failures++; $display("FAIL rm_next_size got=%0d exp=1", rxQ.size()); end
        if (rxQ.size() > 0) begin
            checks++; if (rxQ[0] !== b) begin failures++; $display("FAIL rm_next_byte got=%h exp=%h", rxQ[0], b); end
            checks++; if (rxStop[0] !== 1'b1) begin failures++; $display("FAIL rm_next_stop got=%b exp=1", rxStop[0]); end
        end
        checks++; if (reCount != 1) begin failures++; $display("FAIL rm_read_pulses got=%0d exp=1", reCount); end
    endtask

    task automatic test_checksum();
        bit to;
        apply_reset();
        payQ = '{8'h12, 8'h34};
        foreach (payQ[i]) storeQ.push_back(payQ[i]);
        repeat (3) @(negedge Clock);
        TxEnable = 1'b1;
        model_stream();
        wait_rx(expBytes.size(), 60 * expBytes.size() + 50, to);
        checks++; if (to) begin failures++; $display("FAIL cs_timeout got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        repeat (80) @(negedge Clock);
        checks++; if (rxQ.size() != expBytes.size()) begin failures++; $display("FAIL cs_size got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        for (int i = 0; i < rxQ.size() && i < expBytes.size(); i++) begin
            checks++; if (rxQ[i] !== expBytes[i]) begin failures++; $display("FAIL cs_byte%0d got=%h exp=%h", i, rxQ[i], expBytes[i]); end
        end
        checks++; if (reCount != 2) begin failures++; $display("FAIL cs_read_pulses got=%0d exp=2", reCount); end
        checks++; if (ByteCount !== exp_count(2)) begin failures++; $display("FAIL cs_count got=%0d exp=%0d", ByteCount, exp_count(2)); end
    endtask

    task automatic test_txenable_drop();
        int k;
        bit to;
        apply_reset();
        payQ.push_back(8'($urandom));
        payQ.push_back(8'($urandom));
        foreach (payQ[i]) storeQ.push_back(payQ[i]);
        repeat (3) @(negedge Clock);
        TxEnable = 1'b1;
        k = 0;
        while (Tx !== 1'b0 && k < 20) begin @(negedge Clock); k++; end
        TxEnable = 1'b0;
        repeat (100) @(negedge Clock);
        checks++; if (rxQ.size() != 1) begin failures++; $display("FAIL te_held_size got=%0d exp=1", rxQ.size()); end
        if (rxQ.size() > 0) begin
            checks++; if (rxQ[0] !== payQ[0]) begin failures++; $display("FAIL te_held_byte got=%h exp=%h", rxQ[0], payQ[0]); end
        end
        checks++; if (reCount != 1) begin failures++; $display("FAIL te_held_reads got=%0d exp=1", reCount); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL te_held_busy got=%b exp=0", Busy); end
        TxEnable = 1'b1;
        model_stream();
        wait_rx(expBytes.size(), 60 * expBytes.size() + 50, to);
        checks++; if (to) begin failures++; $display("FAIL te_resume_timeout got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        repeat (60) @(negedge Clock);
        checks++; if (rxQ.size() != expBytes.size()) begin failures++; $display("FAIL te_resume_size got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        for (int i = 0; i < rxQ.size() && i < expBytes.size(); i++) begin
            checks++; if (rxQ[i] !== expBytes[i]) begin failures++; $display("FAIL te_byte%0d got=%h exp=%h", i, rxQ[i], expBytes[i]); end
        end
        checks++; if (reCount != 2) begin failures++; $display("FAIL te_resume_reads got=%0d exp=2", reCount); end
    endtask

    task automatic test_random_stream();
        bit to;
        int gap;
        apply_reset();
        for (int i = 0; i < 6; i++) payQ.push_back(8'($urandom_range(0, 255)));
        foreach (payQ[i]) storeQ.push_back(payQ[i]);
        repeat (3) @(negedge Clock);
        TxEnable = 1'b1;
        model_stream();
        wait_rx(expBytes.size(), 60 * expBytes.size() + 50, to);
        checks++; if (to) begin failures++; $display("FAIL rnd_timeout got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        repeat (60) @(negedge Clock);
        checks++; if (rxQ.size() != expBytes.size()) begin failures++; $display("FAIL rnd_size got=%0d exp=%0d", rxQ.size(), expBytes.size()); end
        for (int i = 0; i < rxQ.size() && i < expBytes.size(); i++) begin
            checks++; if (rxQ[i] !== expBytes[i]) begin failures++; $display("FAIL rnd_byte%0d got=%h exp=%h", i, rxQ[i], expBytes[i]); end
            if (i > 0) begin
                gap = rxStart[i] - rxStart[i-1] - 10 * CPB;
                checks++; if (gap != (expChk[i] ? 0 : 3)) begin failures++; $display("FAIL rnd_gap%0d got=%0d exp=%0d", i, gap, expChk[i] ? 0 : 3); end
            end
        end
        checks++; if (reCount != 6) begin failures++; $display("FAIL rnd_read_pulses got=%0d exp=6", reCount); end
        checks++; if (ByteCount !== exp_count(6)) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", ByteCount, exp_count(6)); end
    endtask

    initial begin : main
        test_reset();
        test_a5_waveform();
        test_back_to_back();
        test_missing_valid();
        test_reset_mid_byte();
        test_checksum();
        test_txenable_drop();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
